// File: rtl/dsp_stim_driver_if.sv
// -----------------------------------------------------------------------------
// dsp_stim_driver_if
// Operand/expectation bus between the stimulus driver and a DSP primitive
// wrapper (and whatever checker compares y against exp).
//   a, b      operands offered to the DUT wrapper
//   valid     a/b are valid this cycle
//   ready     DUT wrapper accepts a/b this cycle
//   exp       expected DUT result, latency-matched to the DUT pipeline
//   exp_valid exp is valid this cycle
// Modports: master = stimulus driver, slave = DUT wrapper / checker side.
// -----------------------------------------------------------------------------
interface dsp_stim_driver_if #(
  parameter int unsigned width = 32
);
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic             valid;
  logic             ready;
  logic [width-1:0] exp;
  logic             exp_valid;

  modport master (
    output a, b, valid, exp, exp_valid,
    input  ready
  );

  modport slave (
    input  a, b, valid, exp, exp_valid,
    output ready
  );
endinterface

// File: rtl/dsp_stim_driver.sv
// -----------------------------------------------------------------------------
// dsp_stim_driver
// Generates a reproducible stream of operand pairs from two 32-bit Galois
// LFSRs for a dsp_* primitive under test, and emits the expected result
// delayed by the DUT latency so a checker can compare y against exp on every
// exp_valid.
//
// Parameters:
//   width   operand/result width (1..32)
//   lat     DUT latency, operand acceptance to y (1..8)
//   seed_a  LFSR A start value (nonzero)
//   seed_b  LFSR B start value (nonzero)
//
// Ports:
//   clock        system clock, posedge
//   reset        synchronous, active-high
//   start        one-cycle run request, honoured only in IDLE
//   op           0 add, 1 sub, 2 mul, 3 and, 4 or, 5 xor, 6 nor, 7 reserved
//   num_vectors  vectors to issue, latched with start
//   bus          dsp_stim_driver_if master: a, b, valid, ready, exp, exp_valid
//   busy         run in progress (RUN or DRAIN)
//   done         one-cycle pulse at the end of a run
//
// Build option: define STIM_CORNER_EN to issue four corner vectors
// (0,0), (all-ones,1), (MSB-only,MSB-only), (all-ones,all-ones) at the head
// of every run before the LFSR stream. Corners count toward num_vectors and
// do not advance the LFSRs.
// -----------------------------------------------------------------------------
module dsp_stim_driver #(
  parameter int unsigned width  = 32,
  parameter int unsigned lat    = 1,
  parameter logic [31:0] seed_a = 32'h0000_0001,
  parameter logic [31:0] seed_b = 32'hDEAD_BEEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [31:0]         num_vectors,
  dsp_stim_driver_if.master   bus,
  output logic                busy,
  output logic                done
);

  localparam logic [31:0] tap_mask = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_NOR  = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ tap_mask) : (s >> 1);
  endfunction

  state_t           state;
  op_t              op_q;
  logic [31:0]      lfsr_a;
  logic [31:0]      lfsr_b;
  logic [31:0]      count;
  logic             valid_q;

  logic [width-1:0] cur_a;
  logic [width-1:0] cur_b;
  logic [width-1:0] exp_now;
  logic             hs;
  logic             start_ok;
  logic             advance_lfsr;

  // Delay line modelling the DUT pipeline: stage lat-1 is the output.
  logic [lat-1:0]   dl_valid;
  logic [width-1:0] dl_data [lat];

  assign hs       = valid_q & bus.ready;
  assign start_ok = start && (op != OP_RSVD);

`ifdef STIM_CORNER_EN
  localparam logic [width-1:0] one_v    = width'(1);
  localparam logic [width-1:0] msb_only = one_v << (width - 1);

  // 0..3 = corner vector being offered, 4 = corners exhausted.
  logic [2:0] corner_idx;
  logic       in_corner;

  assign in_corner    = (corner_idx != 3'd4);
  assign advance_lfsr = ~in_corner;

  always_ff @(posedge clock) begin
    if (reset) begin
      corner_idx <= 3'd0;
    end else if (state == IDLE && start_ok) begin
      corner_idx <= 3'd0;
    end else if (state == RUN && hs && in_corner) begin
      corner_idx <= corner_idx + 3'd1;
    end
  end
`else
  assign advance_lfsr = 1'b1;
`endif

  // Operand source: corner table while it lasts, LFSRs otherwise.
  always_comb begin
    cur_a = lfsr_a[width-1:0];
    cur_b = lfsr_b[width-1:0];
`ifdef STIM_CORNER_EN
    if (in_corner) begin
      case (corner_idx[1:0])
        2'd0:    begin cur_a = '0;       cur_b = '0;       end
        2'd1:    begin cur_a = '1;       cur_b = one_v;    end
        2'd2:    begin cur_a = msb_only; cur_b = msb_only; end
        default: begin cur_a = '1;       cur_b = '1;       end
      endcase
    end
`endif
  end

  // Reference result, truncated to width by the assignment context.
  always_comb begin
    // NOTE: default assignment first so every path drives exp_now; a missing
    // branch would otherwise infer a latch.
    exp_now = '0;
    case (op_q)
      OP_ADD:  exp_now = cur_a + cur_b;
      OP_SUB:  exp_now = cur_a - cur_b;
      OP_MUL:  exp_now = cur_a * cur_b;
      OP_AND:  exp_now = cur_a & cur_b;
      OP_OR:   exp_now = cur_a | cur_b;
      OP_XOR:  exp_now = cur_a ^ cur_b;
      OP_NOR:  exp_now = ~(cur_a | cur_b);
      default: exp_now = '0;
    endcase
  end

  // Free-running delay line: shifts every cycle, bubble when no handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      dl_valid <= '0;
      // NOTE: this storage is cleared on reset on purpose: exp must read zero
      // after reset and a stale entry would hold DRAIN open.
      for (int i = 0; i < int'(lat); i++) dl_data[i] <= '0;
    end else begin
      for (int i = int'(lat) - 1; i > 0; i--) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_data[i]  <= dl_data[i-1];
      end
      dl_valid[0] <= hs;
      dl_data[0]  <= hs ? exp_now : '0;
    end
  end

  // Run control FSM with registered valid/busy/done.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: non-blocking assignments throughout sequential logic so every
      // flop samples pre-edge values regardless of statement order.
      state   <= IDLE;
      op_q    <= OP_ADD;
      lfsr_a  <= seed_a;
      lfsr_b  <= seed_b;
      count   <= '0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            // Reload seeds so every run replays the same sequence.
            lfsr_a <= seed_a;
            lfsr_b <= seed_b;
            op_q   <= op_t'(op);
            if (num_vectors == 32'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              count   <= num_vectors;
              state   <= RUN;
              valid_q <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end

        RUN: begin
          if (hs) begin
            count <= count - 32'd1;
            if (advance_lfsr) begin
              lfsr_a <= lfsr_step(lfsr_a);
              lfsr_b <= lfsr_step(lfsr_b);
            end
            if (count == 32'd1) begin
              state   <= DRAIN;
              valid_q <= 1'b0;
            end
          end
        end

        DRAIN: begin
          if (dl_valid == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.valid     = valid_q;
  assign bus.a         = valid_q ? cur_a : '0;
  assign bus.b         = valid_q ? cur_b : '0;
  assign bus.exp       = dl_data[lat-1];
  assign bus.exp_valid = dl_valid[lat-1];

endmodule

// File: tb/tb_dsp_stim_driver.sv
// -----------------------------------------------------------------------------
// tb_dsp_stim_driver
// Two instances share start/op/num_vectors/ready: an 8-bit lat=1 unit and a
// 32-bit lat=3 unit. A reference model generates the expected operand stream
// per run from the LFSR rule; a monitor compares operands on every handshake,
// queues the expected result with its due cycle, and checks exp/exp_valid
// when they emerge.
// -----------------------------------------------------------------------------
module tb_dsp_stim_driver;

`ifdef STIM_CORNER_EN
  localparam bit corners_on = 1'b1;
`else
  localparam bit corners_on = 1'b0;
`endif

  localparam int w_u   [2] = '{8, 32};
  localparam int lat_u [2] = '{1, 3};
  localparam logic [31:0] seed_a = 32'h0000_0001;
  localparam logic [31:0] seed_b = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] nv    = 32'd0;
  logic        ready = 1'b1;
  bit          ready_rand = 1'b0;

  logic busy8, done8, busy32, done32;

  always #5 clock = ~clock;

  dsp_stim_driver_if #(.width(8))  if8  ();
  dsp_stim_driver_if #(.width(32)) if32 ();

  assign if8.ready  = ready;
  assign if32.ready = ready;

  dsp_stim_driver #(.width(8), .lat(1), .seed_a(seed_a), .seed_b(seed_b)) dut8 (
    .clock(clock), .reset(reset), .start(start), .op(op), .num_vectors(nv),
    .bus(if8), .busy(busy8), .done(done8)
  );

  dsp_stim_driver #(.width(32), .lat(3), .seed_a(seed_a), .seed_b(seed_b)) dut32 (
    .clock(clock), .reset(reset), .start(start), .op(op), .num_vectors(nv),
    .bus(if32), .busy(busy32), .done(done32)
  );

  // Uniform per-unit view of the outputs.
  logic [31:0] s_a [2], s_b [2], s_exp [2];
  logic        s_valid [2], s_ev [2], s_busy [2], s_done [2];
  assign s_a[0] = 32'(if8.a);     assign s_a[1] = if32.a;
  assign s_b[0] = 32'(if8.b);     assign s_b[1] = if32.b;
  assign s_exp[0] = 32'(if8.exp); assign s_exp[1] = if32.exp;
  assign s_valid[0] = if8.valid;  assign s_valid[1] = if32.valid;
  assign s_ev[0] = if8.exp_valid; assign s_ev[1] = if32.exp_valid;
  assign s_busy[0] = busy8;       assign s_busy[1] = busy32;
  assign s_done[0] = done8;       assign s_done[1] = done32;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, wanted %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] val;
    int          due;
  } pend_t;

  pend_t       pq [2][$];
  logic [31:0] m_a [2], m_b [2], m_rem [2];
  int          m_corner [2];
  logic [2:0]  m_op;

  int          hs_cnt [2];
  int          done_cnt [2];
  bit          prev_done [2];
  bit          held [2];
  logic [31:0] hold_a [2], hold_b [2];

  logic [31:0] exp_log8 [$];
  logic [31:0] exp_log32 [$];
  logic [31:0] first_a8, first_b8;
  bit          got_first8;

  function automatic logic [31:0] mask_of(input int u);
    return (w_u[u] == 32) ? 32'hFFFF_FFFF : ((32'h1 << w_u[u]) - 32'h1);
  endfunction

  function automatic logic [31:0] ref_exp(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] msk);
    logic [31:0] r;
    case (o)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x * y;
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      3'd6: r = ~(x | y);
      default: r = 32'h0;
    endcase
    return r & msk;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic model_operands(input int u, output logic [31:0] ea, output logic [31:0] eb);
    logic [31:0] msk, msb;
    msk = mask_of(u);
    msb = 32'h1 << (w_u[u] - 1);
    ea  = m_a[u] & msk;
    eb  = m_b[u] & msk;
    if (corners_on && m_corner[u] < 4) begin
      case (m_corner[u])
        0:       begin ea = 32'h0; eb = 32'h0; end
        1:       begin ea = msk;   eb = 32'h1; end
        2:       begin ea = msb;   eb = msb;   end
        default: begin ea = msk;   eb = msk;   end
      endcase
    end
  endtask

  task automatic model_start(input logic [2:0] o, input logic [31:0] n);
    m_op = o;
    for (int u = 0; u < 2; u++) begin
      m_a[u] = seed_a;
      m_b[u] = seed_b;
      m_rem[u] = n;
      m_corner[u] = 0;
    end
    exp_log8.delete();
    exp_log32.delete();
    got_first8 = 1'b0;
  endtask

  task automatic clear_scoreboard();
    for (int u = 0; u < 2; u++) begin
      pq[u].delete();
      m_rem[u] = 32'd0;
      held[u]  = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    for (int u = 0; u < 2; u++) begin
      hs_cnt[u] = 0; done_cnt[u] = 0; prev_done[u] = 1'b0; held[u] = 1'b0; m_rem[u] = 0;
    end
    forever begin
      @(negedge clock);
      for (int u = 0; u < 2; u++) begin
        // expectation output
        if (s_ev[u] === 1'b1) begin
          if (pq[u].size() == 0) begin
            check($sformatf("u%0d_exp_unexpected", u), 32'(s_ev[u]), 32'd0);
          end else begin
            pend_t p;
            p = pq[u].pop_front();
            check($sformatf("u%0d_exp_value", u), s_exp[u], p.val);
            check($sformatf("u%0d_exp_cycle", u), cyc, p.due);
          end
          if (u == 0) exp_log8.push_back(s_exp[u]);
          else        exp_log32.push_back(s_exp[u]);
        end else if (pq[u].size() > 0 && pq[u][0].due <= cyc) begin
          check($sformatf("u%0d_exp_missing", u), 32'(s_ev[u]), 32'd1);
          void'(pq[u].pop_front());
        end

        // operands held while stalled
        if (held[u] && s_valid[u] === 1'b1) begin
          check($sformatf("u%0d_stall_a", u), s_a[u], hold_a[u]);
          check($sformatf("u%0d_stall_b", u), s_b[u], hold_b[u]);
        end
        held[u]   = (s_valid[u] === 1'b1) && !ready && !reset;
        hold_a[u] = s_a[u];
        hold_b[u] = s_b[u];

        // handshake: compare operands, schedule the expected result
        if (s_valid[u] === 1'b1 && ready && !reset) begin
          hs_cnt[u]++;
          if (m_rem[u] == 32'd0) begin
            check($sformatf("u%0d_valid_unexpected", u), 32'(s_valid[u]), 32'd0);
          end else begin
            logic [31:0] ea, eb;
            pend_t p;
            model_operands(u, ea, eb);
            check($sformatf("u%0d_a", u), s_a[u], ea);
            check($sformatf("u%0d_b", u), s_b[u], eb);
            p.val = ref_exp(m_op, ea, eb, mask_of(u));
            p.due = cyc + lat_u[u];
            pq[u].push_back(p);
            if (u == 0 && !got_first8) begin
              first_a8 = s_a[u]; first_b8 = s_b[u]; got_first8 = 1'b1;
            end
            if (corners_on && m_corner[u] < 4) begin
              m_corner[u]++;
            end else begin
              m_a[u] = lfsr_next(m_a[u]);
              m_b[u] = lfsr_next(m_b[u]);
            end
            m_rem[u]--;
          end
        end

        // done pulse bookkeeping
        if (s_done[u] === 1'b1) begin
          done_cnt[u]++;
          check($sformatf("u%0d_done_width", u), 32'(prev_done[u]), 32'd0);
          check($sformatf("u%0d_busy_at_done", u), 32'(s_busy[u]), 32'd0);
        end
        prev_done[u] = (s_done[u] === 1'b1);
      end
    end
  end

  // ---------------- random ready driver ----------------
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (ready_rand) ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [2:0] o, input logic [31:0] n);
    start = 1'b1; op = o; nv = n;
    tick(1);
    start = 1'b0;
    if (o != 3'd7) model_start(o, n);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0, d1, t;
    d0 = done_cnt[0]; d1 = done_cnt[1]; t = 0;
    while ((done_cnt[0] == d0 || done_cnt[1] == d1) && t < budget) begin
      tick(1);
      t++;
    end
    check({tag, "_completes"}, 32'(t < budget), 32'd1);
    tick(2);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s_u%0d_done_count", tag, u), done_cnt[u] - (u == 0 ? d0 : d1), 1);
      check($sformatf("%s_u%0d_all_issued", tag, u), m_rem[u], 32'd0);
      check($sformatf("%s_u%0d_all_emerged", tag, u), pq[u].size(), 0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s_u%0d_data", tag, u), s_a[u] | s_b[u] | s_exp[u], 32'd0);
      check($sformatf("%s_u%0d_ctrl", tag, u),
            {28'd0, s_valid[u], s_ev[u], s_busy[u], s_done[u]}, 32'd0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    clear_scoreboard();
    @(negedge clock);
    check_idle_outputs("after_reset");
    tick(0);
  endtask

  initial begin
    int h0, d0, d1, t;

    // ---- reset state ----
    tick(2);
    @(negedge clock);
    check_idle_outputs("reset");
    tick(0);
    reset = 1'b0;
    tick(1);

    // ---- add, two vectors, ready high ----
    ready = 1'b1;
    do_start(3'd0, 32'd2);
    @(negedge clock);
    check("busy8_after_start", 32'(busy8), 32'd1);
    check("busy32_after_start", 32'(busy32), 32'd1);
    tick(0);
    wait_done("add2", 100);
`ifndef STIM_CORNER_EN
    check("add2_first_a", first_a8, 32'h01);
    check("add2_first_b", first_b8, 32'hEF);
    check("add2_exp_count", exp_log8.size(), 2);
    if (exp_log8.size() == 2) begin
      check("add2_exp0", exp_log8[0], 32'hF0);
      check("add2_exp1", exp_log8[1], 32'h77);
    end
`endif

    // ---- sub, one vector, ready low for three cycles ----
    ready = 1'b0;
    do_start(3'd1, 32'd1);
    tick(3);
    ready = 1'b1;
    wait_done("sub_stall", 100);
`ifndef STIM_CORNER_EN
    check("sub_exp_count", exp_log8.size(), 1);
    if (exp_log8.size() == 1) check("sub_exp0", exp_log8[0], 32'h12);
`endif

    // ---- mul, one vector: checks the 32-bit lat=3 unit ----
    do_start(3'd2, 32'd1);
    wait_done("mul1", 100);
`ifndef STIM_CORNER_EN
    check("mul32_exp_count", exp_log32.size(), 1);
    if (exp_log32.size() == 1) check("mul32_exp0", exp_log32[0], 32'hDEAD_BEEF);
`endif

    // ---- reserved op is ignored ----
    h0 = hs_cnt[0]; d0 = done_cnt[0]; d1 = done_cnt[1];
    do_start(3'd7, 32'd4);
    tick(4);
    check("op7_busy8", 32'(busy8), 32'd0);
    check("op7_busy32", 32'(busy32), 32'd0);
    check("op7_no_issue", hs_cnt[0] - h0, 0);
    check("op7_no_done", (done_cnt[0] - d0) + (done_cnt[1] - d1), 0);

    // ---- zero vectors: done next cycle, no valid ----
    h0 = hs_cnt[0];
    do_start(3'd0, 32'd0);
    @(negedge clock);
    check("nv0_done8", 32'(done8), 32'd1);
    check("nv0_done32", 32'(done32), 32'd1);
    tick(0);
    tick(3);
    check("nv0_no_issue", hs_cnt[0] - h0, 0);

    // ---- reset after 5 of 10 vectors, then replay ----
    h0 = hs_cnt[0];
    do_start(3'd5, 32'd10);
    t = 0;
    while (hs_cnt[0] - h0 < 5 && t < 100) begin tick(1); t++; end
    check("midrun_reached5", 32'(t < 100), 32'd1);
    d0 = done_cnt[0]; d1 = done_cnt[1];
    do_reset();
    tick(5);
    check("midrun_no_done", (done_cnt[0] - d0) + (done_cnt[1] - d1), 0);
    do_start(3'd0, 32'd3);
    wait_done("replay", 100);
`ifdef STIM_CORNER_EN
    check("replay_first_a", first_a8, 32'h00);
`else
    check("replay_first_a", first_a8, 32'h01);
`endif

    // ---- maximal num_vectors: no wrap, stays busy; abort with reset ----
    do_start(3'd3, 32'hFFFF_FFFF);
    ready_rand = 1'b1;
    tick(40);
    check("max_nv_busy8", 32'(busy8), 32'd1);
    check("max_nv_busy32", 32'(busy32), 32'd1);
    ready_rand = 1'b0;
    ready = 1'b1;
    do_reset();

`ifdef STIM_CORNER_EN
    // ---- corner vectors then the LFSR stream ----
    do_start(3'd4, 32'd5);
    wait_done("corner", 100);
    check("corner_exp_count", exp_log8.size(), 5);
    if (exp_log8.size() == 5) begin
      check("corner_exp0", exp_log8[0], 32'h00);
      check("corner_exp1", exp_log8[1], 32'hFF);
      check("corner_exp2", exp_log8[2], 32'h80);
      check("corner_exp3", exp_log8[3], 32'hFF);
      check("corner_exp4", exp_log8[4], 32'hEF);
    end
`endif

    // ---- randomized runs with random ready, ignored mid-run inputs ----
    for (int r = 0; r < 10; r++) begin
      logic [2:0]  rop;
      logic [31:0] rnv;
      rop = 3'($urandom_range(0, 6));
      rnv = 32'($urandom_range(3, 12));
      do_start(rop, rnv);
      ready_rand = 1'b1;
      op = 3'($urandom);
      nv = $urandom;
      tick(2);
      start = 1'b1;
      op = 3'd3;
      nv = 32'd7;
      tick(1);
      start = 1'b0;
      wait_done($sformatf("rand%0d", r), 400);
      ready_rand = 1'b0;
      ready = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
